// File: rtl/fp_mul_prenorm_pkg.sv
// Shared types for the fp_mul pre-normalization stage: operand formats, special-case flags,
// the fp_mul argument bundle and the pipeline payload carried between the two stages.
package fp_mul_prenorm_pkg;

  localparam int FRAC_WIDTH = 52;
  localparam int EXPO_WIDTH = 11;
  localparam int ID_WIDTH   = 4;

  typedef struct packed {
    logic include_fpu;
    logic fpu_double;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{include_fpu: 1'b1, fpu_double: 1'b1};

  typedef logic [63:0]         fp_t;
  typedef logic [2:0]          rm_t;
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [5:0]          fp_shift_amt_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
  } fp_special_case_t;

  typedef struct packed {
    fp_t  rs3;
    logic add;
    logic neg;
  } fp_fma_inputs_t;

  typedef struct packed {
    fp_t              rs1;
    fp_t              rs2;
    logic             rs1_hidden_bit;
    logic             rs2_hidden_bit;
    fp_special_case_t rs1_special_case;
    fp_special_case_t rs2_special_case;
    rm_t              rm;
    logic             single;
    fp_shift_amt_t    rs2_prenormalize_shift_amt;
  } fp_mul_inputs_t;

  typedef struct packed {
    id_t            id;
    fp_mul_inputs_t mul;
    logic           fma;
    fp_fma_inputs_t fma_args;
  } prenorm_pipe_t;

  function automatic fp_special_case_t classify(input logic [EXPO_WIDTH-1:0] expo,
                                                input logic [FRAC_WIDTH-1:0] frac);
    fp_special_case_t sc;
    sc.zero = ~|expo & ~|frac;
    sc.inf  = &expo & ~|frac;
    sc.qnan = &expo & frac[FRAC_WIDTH-1];
    sc.snan = &expo & ~frac[FRAC_WIDTH-1] & |frac;
    return sc;
  endfunction

  // Position of the first set bit counting from x[3]; 3 when x is all zero.
  function automatic logic [1:0] pri4(input logic [3:0] x);
    if (x[3])      return 2'd0;
    else if (x[2]) return 2'd1;
    else if (x[1]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/fp_prenorm_clz.sv
// Combinational 52-bit leading-zero counter built as a three-level tree of 4-bit priority cells.
module fp_prenorm_clz
  import fp_mul_prenorm_pkg::*;
(
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output fp_shift_amt_t         cnt_o
);

  // Low padding of ones squares the tree to 64 bits; an all-zero fraction then reads as 52.
  logic [63:0] padded;
  logic [15:0] nib_v;
  logic [1:0]  nib_c [16];
  logic [3:0]  grp_v;
  logic [1:0]  grp_sel [4];
  logic [3:0]  grp_c [4];
  logic [1:0]  top_sel;

  assign padded = {frac_i, 12'hFFF};

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      nib_v[i] = |padded[63-4*i -: 4];
      nib_c[i] = pri4(padded[63-4*i -: 4]);
    end
    for (int g = 0; g < 4; g++) begin
      grp_sel[g] = pri4({nib_v[4*g], nib_v[4*g+1], nib_v[4*g+2], nib_v[4*g+3]});
      grp_v[g]   = |nib_v[4*g +: 4];
      grp_c[g]   = {grp_sel[g], nib_c[4*g + int'(grp_sel[g])]};
    end
    top_sel = pri4({grp_v[0], grp_v[1], grp_v[2], grp_v[3]});
    cnt_o   = {top_sel, grp_c[top_sel]};
  end

endmodule

// File: rtl/fp_mul_prenorm.sv
// Two-stage elastic pre-normalizer ahead of fp_mul: classify and steer a lone subnormal into rs2,
// then left-normalize its fraction and report the shift so fp_mul only sees subnormals in rs2.
module fp_mul_prenorm
  import fp_mul_prenorm_pkg::*;
#(
  parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  id_t            in_id,
  input  fp_t            in_rs1,
  input  fp_t            in_rs2,
  input  rm_t            in_rm,
  input  logic           in_single,
  input  logic           in_fma,
  input  fp_fma_inputs_t in_fma_args,
  output logic           out_valid,
  input  logic           out_ready,
  output id_t            out_id,
  output fp_mul_inputs_t out_mul_args,
  output logic           out_fma,
  output fp_fma_inputs_t out_fma_args
);

  localparam logic FPU_EN = CONFIG.include_fpu;

  // Handshake: a transfer happens on a posedge where valid && ready. Each stage register loads when
  // it is empty or its contents move on; in_ready is stage 1's load enable.
  logic advance_1, advance_2;

  logic          v1_q, v1_d, v2_q, v2_d;
  prenorm_pipe_t s1_q, s1_d, s1_new;
  prenorm_pipe_t s2_q, s2_d, s2_new;
  fp_shift_amt_t s1_clz_q, s1_clz_d, clz_cnt, shamt;

  logic             h_a, h_b, sub_a, sub_b, swap;
  fp_special_case_t sc_a, sc_b;
  logic             rs1_sub, rs2_sub, prenorm;

  assign advance_2 = ~v2_q | out_ready;
  assign advance_1 = ~v1_q | advance_2;
  assign in_ready  = advance_1;

  always_comb begin
    h_a   = |in_rs1[62:52];
    h_b   = |in_rs2[62:52];
    sc_a  = classify(in_rs1[62:52], in_rs1[51:0]);
    sc_b  = classify(in_rs2[62:52], in_rs2[51:0]);
    sub_a = ~h_a & |in_rs1[51:0];
    sub_b = ~h_b & |in_rs2[51:0];
    swap  = sub_a & ~sub_b;

    s1_new.id                             = in_id;
    s1_new.mul.rs1                        = swap ? in_rs2 : in_rs1;
    s1_new.mul.rs2                        = swap ? in_rs1 : in_rs2;
    s1_new.mul.rs1_hidden_bit             = swap ? h_b : h_a;
    s1_new.mul.rs2_hidden_bit             = swap ? h_a : h_b;
    s1_new.mul.rs1_special_case           = swap ? sc_b : sc_a;
    s1_new.mul.rs2_special_case           = swap ? sc_a : sc_b;
    s1_new.mul.rm                         = in_rm;
    s1_new.mul.single                     = in_single | ~CONFIG.fpu_double;
    s1_new.mul.rs2_prenormalize_shift_amt = '0;
    s1_new.fma                            = in_fma;
    s1_new.fma_args                       = in_fma_args;
  end

  fp_prenorm_clz u_clz (
    .frac_i (s1_new.mul.rs2[FRAC_WIDTH-1:0]),
    .cnt_o  (clz_cnt)
  );

  always_comb begin
    v1_d     = v1_q;
    s1_d     = s1_q;
    s1_clz_d = s1_clz_q;
    if (advance_1) begin
      v1_d     = in_valid & FPU_EN;
      s1_d     = s1_new;
      s1_clz_d = clz_cnt;
    end
  end

  // Both-subnormal pairs are left alone; fp_mul flushes them through its subnormal-zero path.
  always_comb begin
    rs1_sub = ~s1_q.mul.rs1_hidden_bit & ~s1_q.mul.rs1_special_case.zero;
    rs2_sub = ~s1_q.mul.rs2_hidden_bit & ~s1_q.mul.rs2_special_case.zero;
    prenorm = rs2_sub & ~rs1_sub;
    shamt   = s1_clz_q + 6'd1;
    s2_new  = s1_q;
    if (prenorm) begin
      s2_new.mul.rs2[FRAC_WIDTH-1:0]        = s1_q.mul.rs2[FRAC_WIDTH-1:0] << shamt;
      s2_new.mul.rs2_prenormalize_shift_amt = shamt;
    end
  end

  always_comb begin
    v2_d = v2_q;
    s2_d = s2_q;
    if (advance_2) begin
      v2_d = v1_q;
      s2_d = s2_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q     <= s1_d;
    s1_clz_q <= s1_clz_d;
    s2_q     <= s2_d;
  end

  assign out_valid    = v2_q;
  assign out_id       = s2_q.id;
  assign out_mul_args = s2_q.mul;
  assign out_fma      = s2_q.fma;
  assign out_fma_args = s2_q.fma_args;

endmodule

// File: tb/tb_fp_mul_prenorm.sv
// Directed bench for fp_mul_prenorm: hand-computed operand steering/normalization vectors,
// stall/backpressure ordering and mid-flight reset, with an id scoreboard on the output port.
module tb_fp_mul_prenorm;
  import fp_mul_prenorm_pkg::*;

  localparam fp_t ONE  = 64'h3FF0000000000000;
  localparam fp_t TWO  = 64'h4000000000000000;
  localparam fp_t PINF = 64'h7FF0000000000000;
  localparam fp_t SNAN = 64'h7FF0000000000001;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_single, in_fma;
  id_t            in_id, out_id;
  fp_t            in_rs1, in_rs2;
  rm_t            in_rm;
  fp_fma_inputs_t in_fma_args, out_fma_args;
  logic           out_valid, out_ready, out_fma;
  fp_mul_inputs_t out_mul_args;

  logic [ID_WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_prenorm #(.CONFIG(EXAMPLE_CONFIG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_id        (in_id),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rm        (in_rm),
    .in_single    (in_single),
    .in_fma       (in_fma),
    .in_fma_args  (in_fma_args),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_mul_args (out_mul_args),
    .out_fma      (out_fma),
    .out_fma_args (out_fma_args)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_mul(input string tag, input fp_t rs1, input fp_t rs2,
                           input logic h1, input logic h2, input logic [3:0] sc1,
                           input logic [3:0] sc2, input logic [5:0] sh);
    check_eq({tag, "_rs1"}, out_mul_args.rs1, rs1);
    check_eq({tag, "_rs2"}, out_mul_args.rs2, rs2);
    check_eq({tag, "_h1"}, 64'(out_mul_args.rs1_hidden_bit), 64'(h1));
    check_eq({tag, "_h2"}, 64'(out_mul_args.rs2_hidden_bit), 64'(h2));
    check_eq({tag, "_sc1"}, 64'(out_mul_args.rs1_special_case), 64'(sc1));
    check_eq({tag, "_sc2"}, 64'(out_mul_args.rs2_special_case), 64'(sc2));
    check_eq({tag, "_shift"}, 64'(out_mul_args.rs2_prenormalize_shift_amt), 64'(sh));
  endtask

  // Single request into an idle pipe with out_ready high; checks the two-cycle latency.
  task automatic run_one(input id_t id, input fp_t a, input fp_t b);
    in_id    = id;
    in_rs1   = a;
    in_rs2   = b;
    in_valid = 1'b1;
    exp_q.push_back(id);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("lat1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat2_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic send_req(input id_t id, input fp_t a, input fp_t b);
    logic acc;
    int   n;
    n        = 0;
    in_id    = id;
    in_rs1   = a;
    in_rs2   = b;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 40);
    in_valid = 1'b0;
    check_eq("send_accept", 64'(acc), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("spurious_out", 64'(out_valid), 64'd0);
      else check_eq("out_order_id", 64'(out_id), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_id       = '0;
    in_rs1      = '0;
    in_rs2      = '0;
    in_rm       = 3'd3;
    in_single   = 1'b1;
    in_fma      = 1'b1;
    in_fma_args = '{rs3: 64'hC0DE_0000_1234_5678, add: 1'b1, neg: 1'b0};
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1.0 x 2.0 with side-band pass-through
    run_one(4'd5, ONE, TWO);
    check_mul("norm", ONE, TWO, 1'b1, 1'b1, 4'b0000, 4'b0000, 6'd0);
    check_eq("norm_id", 64'(out_id), 64'd5);
    check_eq("norm_rm", 64'(out_mul_args.rm), 64'd3);
    check_eq("norm_single", 64'(out_mul_args.single), 64'd1);
    check_eq("norm_fma", 64'(out_fma), 64'd1);
    check_eq("norm_fma_args", 64'(out_fma_args), 64'({64'hC0DE_0000_1234_5678, 1'b1, 1'b0}));
    in_fma    = 1'b0;
    in_single = 1'b0;
    in_rm     = 3'd0;

    // Subnormal rs1 swapped behind normal rs2; frac bit 51 set -> shift 1, frac becomes 0
    run_one(4'd1, 64'h0008000000000000, TWO);
    check_mul("swap", TWO, 64'h0, 1'b1, 1'b0, 4'b0000, 4'b0000, 6'd1);

    // Smallest subnormal in rs2 -> shift 52
    run_one(4'd2, ONE, 64'h0000000000000001);
    check_mul("min_sub", ONE, 64'h0, 1'b1, 1'b0, 4'b0000, 4'b0000, 6'd52);

    // Both subnormal: no swap, no shift
    run_one(4'd3, 64'h1, 64'h1);
    check_mul("both_sub", 64'h1, 64'h1, 1'b0, 1'b0, 4'b0000, 4'b0000, 6'd0);

    // Negative subnormal 0x1234 (msb at bit 12): clz 39, shift 40, sign kept
    run_one(4'd4, ONE, 64'h8000000000001234);
    check_mul("neg_sub", ONE, 64'h8002340000000000, 1'b1, 1'b0, 4'b0000, 4'b0000, 6'd40);

    // +inf x +0
    run_one(4'd6, PINF, 64'h0);
    check_mul("inf_zero", PINF, 64'h0, 1'b1, 1'b0, 4'b0100, 4'b1000, 6'd0);

    // signalling NaN x 1.0
    run_one(4'd7, SNAN, ONE);
    check_mul("snan", SNAN, ONE, 1'b1, 1'b1, 4'b0001, 4'b0000, 6'd0);

    // quiet NaN in rs2 beside a subnormal rs1: special non-subnormal rs2 forces the swap
    run_one(4'd8, 64'h0000000000000010, 64'h7FF8000000000000);
    check_mul("qnan_swap", 64'h7FF8000000000000, 64'h0, 1'b1, 1'b0, 4'b0010, 4'b0000, 6'd48);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two fill the pipe, third waits until out_ready returns
    out_ready = 1'b0;
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd10);
    exp_q.push_back(4'd11);
    send_req(4'd9, ONE, TWO);
    send_req(4'd10, TWO, ONE);
    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    check_eq("stall_out_valid", 64'(out_valid), 64'd1);
    in_id    = 4'd11;
    in_rs1   = ONE;
    in_rs2   = ONE;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("stall_hold_ready", 64'(in_ready), 64'd0);
      check_eq("stall_hold_id", 64'(out_id), 64'd9);
      check_eq("stall_hold_rs1", out_mul_args.rs1, ONE);
    end
    out_ready = 1'b1;
    #1 check_eq("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two requests in flight discards both
    out_ready = 1'b0;
    send_req(4'd12, ONE, TWO);
    send_req(4'd13, ONE, TWO);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("midrst_quiet", 64'(out_valid), 64'd0);
    end
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    run_one(4'd14, TWO, 64'h0000000000000003);
    check_mul("after_rst", TWO, 64'h8000000000000, 1'b1, 1'b0, 4'b0000, 4'b0000, 6'd51);

    repeat (4) @(posedge clk);
    #1;
    check_eq("final_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
